// File: rtl/ps2_scan_receiver_pkg.sv
// Shared constants and types for the PS/2 scan-code receiver.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package ps2_pkg;

  // Prefix bytes that modify the following scan code instead of producing an event
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Frame deframer states
  typedef logic [1:0] ps2_state_t;
  localparam ps2_state_t IDLE   = 2'd0;
  localparam ps2_state_t DATA   = 2'd1;
  localparam ps2_state_t PARITY = 2'd2;
  localparam ps2_state_t STOP   = 2'd3;

  // One decoded key event as stored in the event FIFO
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  // Increment that sticks at 255
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ps2_scan_receiver_if.sv
// Key-event valid/ready channel between the receiver and its consumer.
// Latency: n/a (wiring only).
// Backpressure: producer holds payload while evt_valid & !evt_ready.
interface ps2_scan_receiver_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;

  modport master (output evt_valid, output evt_code, output evt_ext, output evt_break,
                  input  evt_ready);
  modport slave  (input  evt_valid, input  evt_code, input  evt_ext, input  evt_break,
                  output evt_ready);
endinterface

// File: rtl/ps2_scan_receiver_line_filter.sv
// Synchronises one asynchronous PS/2 line and debounces it with a run-length counter.
// Latency: 2 sync stages + FILTER_CYCLES equal samples before dout follows din.
// Backpressure: none. Ports: clk, rst, din (async pin), dout (filtered, resets high).
module ps2_line_filter #(
  parameter int FILTER_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(FILTER_CYCLES + 1);

  logic          sync1, sync2;
  logic [CW-1:0] run_cnt;

  // run_cnt counts consecutive synchronised samples that disagree with dout;
  // any agreeing sample restarts the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      run_cnt <= '0;
      dout    <= 1'b1;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 == dout) begin
        run_cnt <= '0;
      end else if (run_cnt == CW'(FILTER_CYCLES - 1)) begin
        dout    <= sync2;
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard receiver: filters kclk/kdata, deframes 11-bit frames, folds E0/F0 into events.
// Latency: evt_valid rises the cycle after byte_strobe when the FIFO is empty.
// Backpressure: evt valid/ready; events arriving at a full FIFO are dropped with an overflow pulse.
// Ports: clk, rst (async high), kclk/kdata (async pins), evt (master channel), fifo_count,
//        history (newest byte in [7:0]), frame_err/overflow (1-cycle pulses), err_count (saturating).
module ps2_scan_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_CYCLES  = 20,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 8,
  parameter int HISTORY_BYTES  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         kclk,
  input  logic                         kdata,
  ps2_scan_receiver_if.master          evt,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic [8*HISTORY_BYTES-1:0]   history,
  output logic                         frame_err,
  output logic [7:0]                   err_count,
  output logic                         overflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic kclk_f, kdata_f, kclk_q, kclk_fall;

  ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_kclk_filt (
    .clk(clk), .rst(rst), .din(kclk), .dout(kclk_f));
  ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_kdata_filt (
    .clk(clk), .rst(rst), .din(kdata), .dout(kdata_f));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) kclk_q <= 1'b1;
    else     kclk_q <= kclk_f;
  end
  assign kclk_fall = kclk_q & ~kclk_f;

  // ---------------- deframer ----------------
  ps2_state_t    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tcnt;
  logic          byte_strobe;

  // shreg is left untouched after the stop edge, so it still holds the byte during byte_strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_bit     <= 1'b0;
      tcnt        <= '0;
      byte_strobe <= 1'b0;
      frame_err   <= 1'b0;
      err_count   <= '0;
    end else begin
      byte_strobe <= 1'b0;
      frame_err   <= 1'b0;
      if (kclk_fall) begin
        tcnt <= '0;
        case (state)
          IDLE: begin
            if (!kdata_f) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shreg   <= {kdata_f, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= kdata_f;
            state   <= STOP;
          end
          default: begin
            state <= IDLE;
            // odd parity over data+parity, and a high stop bit
            if ((^shreg ^ par_bit) && kdata_f) begin
              byte_strobe <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              err_count <= sat_inc8(err_count);
            end
          end
        endcase
      end else if (state != IDLE) begin
        if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state     <= IDLE;
          tcnt      <= '0;
          frame_err <= 1'b1;
          err_count <= sat_inc8(err_count);
        end else begin
          tcnt <= tcnt + TW'(1);
        end
      end else begin
        tcnt <= '0;
      end
    end
  end

  // ---------------- prefix folding + event FIFO ----------------
  logic     ext_flag, brk_flag;
  logic     push_req, push, pop;
  ps2_evt_t push_evt;
  ps2_evt_t mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  always_comb begin
    push_req = byte_strobe && (shreg != PS2_EXT) && (shreg != PS2_BRK);
    push_evt = '{ext: ext_flag, brk: brk_flag, code: shreg};
    pop      = evt.evt_valid & evt.evt_ready;
    // a pop in the same cycle frees the slot the push writes into
    push     = push_req && ((fifo_count < CW'(FIFO_DEPTH)) || pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_flag   <= 1'b0;
      brk_flag   <= 1'b0;
      history    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      overflow <= push_req && !push;
      if (byte_strobe) begin
        history <= {history[8*HISTORY_BYTES-9:0], shreg};
        if (shreg == PS2_EXT) begin
          ext_flag <= 1'b1;
        end else if (shreg == PS2_BRK) begin
          brk_flag <= 1'b1;
        end else begin
          // flags clear even when the event itself is dropped
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
        end
      end
      if (push) begin
        mem[wr_ptr] <= push_evt;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign evt.evt_valid = (fifo_count != '0);
  assign evt.evt_code  = mem[rd_ptr].code;
  assign evt.evt_ext   = mem[rd_ptr].ext;
  assign evt.evt_break = mem[rd_ptr].brk;

endmodule
